// File: rtl/reg_bank_pkg.sv
// Shared CPU constants and types used by the register bank.
package reg_bank_pkg;

    typedef logic [4:0]         reg_idx_t;
    typedef logic signed [31:0] word_t;
    typedef logic [3:0]         nzcv_t;

    localparam int       NREGS  = 15;
    localparam reg_idx_t LR_IDX = 5'd14;
    localparam reg_idx_t PC_IDX = 5'd15;

    typedef word_t regs_t [NREGS];

endpackage

// File: rtl/reg_bank.sv
// Register file R0..R14 plus NZCV flags, with write-through read bypass,
// link-register priority and a registered branch request on writes to R15.
module reg_bank
    import reg_bank_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [4:0]         Rd_s,
    input  logic signed [31:0] word,
    input  logic               enable_reg_s,
    input  logic               condition_s,
    input  logic               link_s,
    input  logic [31:0]        pc_val_s,
    input  logic               set_s,
    input  logic [3:0]         flags_in,
    input  logic [4:0]         Rn,
    input  logic [4:0]         Rm,
    output logic signed [31:0] Rn_val,
    output logic signed [31:0] Rm_val,
    input  logic [31:0]        pc_fetch,
    output logic [3:0]         flags,
    output logic               pc_load,
    output logic [31:0]        pc_target
);

    regs_t       regs_q, regs_d;
    nzcv_t       flags_q, flags_d;
    logic        pc_load_q, pc_load_d;
    logic [31:0] pc_target_q, pc_target_d;

    logic wr_gen, wr_pc, wr_link, wr_flags;

    // regs_d is both the next state and the bypassed read view of the bank.
    function automatic word_t read_port(input regs_t regs, input reg_idx_t idx,
                                        input logic [31:0] pc);
        if (idx == PC_IDX)
            return word_t'(pc);
        else if (idx[4])
            return '0;
        else
            return regs[idx[3:0]];
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        regs_d      = regs_q;
        flags_d     = flags_q;
        pc_target_d = pc_target_q;

        wr_gen   = enable_reg_s && condition_s && (Rd_s < PC_IDX);
        wr_pc    = enable_reg_s && condition_s && (Rd_s == PC_IDX);
        wr_link  = link_s && condition_s;
        wr_flags = set_s && condition_s;

        if (wr_gen)
            regs_d[Rd_s[3:0]] = word;
        // Link is applied last so it overrides a same-cycle general write to LR.
        if (wr_link)
            regs_d[LR_IDX[3:0]] = word_t'(pc_val_s);
        if (wr_flags)
            flags_d = flags_in;

        pc_load_d = wr_pc;
        if (wr_pc)
            pc_target_d = word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the whole bank is cleared on reset, so it cannot map onto a reset-less RAM macro.
        if (!reset_n) begin
            regs_q      <= '{default: '0};
            flags_q     <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only.
            regs_q      <= regs_d;
            flags_q     <= flags_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
        end
    end

    assign Rn_val    = read_port(regs_d, Rn, pc_fetch);
    assign Rm_val    = read_port(regs_d, Rm, pc_fetch);
    assign flags     = flags_d;
    assign pc_load   = pc_load_q;
    assign pc_target = pc_target_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_reg_bank;

    logic               clk;
    logic               reset_n;
    logic [4:0]         Rd_s;
    logic signed [31:0] word;
    logic               enable_reg_s;
    logic               condition_s;
    logic               link_s;
    logic [31:0]        pc_val_s;
    logic               set_s;
    logic [3:0]         flags_in;
    logic [4:0]         Rn, Rm;
    logic signed [31:0] Rn_val, Rm_val;
    logic [31:0]        pc_fetch;
    logic [3:0]         flags;
    logic               pc_load;
    logic [31:0]        pc_target;

    reg_bank dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .Rd_s         (Rd_s),
        .word         (word),
        .enable_reg_s (enable_reg_s),
        .condition_s  (condition_s),
        .link_s       (link_s),
        .pc_val_s     (pc_val_s),
        .set_s        (set_s),
        .flags_in     (flags_in),
        .Rn           (Rn),
        .Rm           (Rm),
        .Rn_val       (Rn_val),
        .Rm_val       (Rm_val),
        .pc_fetch     (pc_fetch),
        .flags        (flags),
        .pc_load      (pc_load),
        .pc_target    (pc_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [31:0] m_regs [15];
    logic [3:0]  m_flags;
    logic        m_pc_load;
    logic [31:0] m_pc_target;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
        m_flags     = '0;
        m_pc_load   = 1'b0;
        m_pc_target = '0;
    endtask

    // What a decode read must see this cycle, including the pending write.
    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd15) return pc_fetch;
        if (idx > 5'd15)  return '0;
        if (condition_s && link_s && idx == 5'd14) return pc_val_s;
        if (condition_s && enable_reg_s && Rd_s == idx) return word;
        return m_regs[idx];
    endfunction

    task automatic drive(input logic [4:0] rd, input logic [31:0] wd, input logic en,
                         input logic cond, input logic lnk, input logic [31:0] pcv,
                         input logic st, input logic [3:0] fl,
                         input logic [4:0] rn_i, input logic [4:0] rm_i, input logic [31:0] pcf);
        Rd_s = rd; word = wd; enable_reg_s = en; condition_s = cond; link_s = lnk;
        pc_val_s = pcv; set_s = st; flags_in = fl; Rn = rn_i; Rm = rm_i; pc_fetch = pcf;
    endtask

    // Called 1 time unit after a rising edge; checks reads, clocks, checks registered outputs.
    task automatic cycle(input string tag);
        #2;
        check({tag, "_rn"}, Rn_val, exp_read(Rn));
        check({tag, "_rm"}, Rm_val, exp_read(Rm));
        check({tag, "_flags"}, {28'd0, flags},
              {28'd0, (condition_s && set_s) ? flags_in : m_flags});
        @(posedge clk);
        m_pc_load = 1'b0;
        if (condition_s) begin
            if (enable_reg_s && Rd_s < 5'd15) m_regs[Rd_s] = word;
            if (link_s) m_regs[14] = pc_val_s;
            if (set_s) m_flags = flags_in;
            if (enable_reg_s && Rd_s == 5'd15) begin
                m_pc_load   = 1'b1;
                m_pc_target = word;
            end
        end
        #1;
        check({tag, "_pc_load"}, {31'd0, pc_load}, {31'd0, m_pc_load});
        check({tag, "_pc_target"}, pc_target, m_pc_target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        reset_n = 1'b0;
        drive(5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 5'd3, 5'd7, 32'h0000_0400);
        #12;
        check("rst_rn", Rn_val, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_pc_load", {31'd0, pc_load}, 32'd0);
        check("rst_pc_target", pc_target, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Bypass on write of R3, then the stored value after the edge.
        drive(5'd3, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd3, 5'd3, 32'h400);
        #2 check("r3_bypass", Rn_val, 32'h1234_5678);
        #0 check("r3_bypass_rm", Rm_val, 32'h1234_5678);
        #(-0);
        @(posedge clk); m_regs[3] = 32'h1234_5678; #1;
        drive(5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd3, 5'd5, 32'h400);
        #2 check("r3_held", Rn_val, 32'h1234_5678);
        @(posedge clk); #1;

        // Failed condition: no write, no flag update, no bypass.
        drive(5'd5, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 4'hF, 5'd5, 5'd3, 32'h400);
        cycle("cond0");
        drive(5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd5, 5'd3, 32'h400);
        #2 check("r5_unchanged", Rn_val, 32'd0);
        check("flags_unchanged", {28'd0, flags}, 32'd0);
        @(posedge clk); #1;

        // Link beats a general write to R14.
        drive(5'd14, 32'h55, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 4'd0, 5'd14, 5'd14, 32'h400);
        cycle("link");
        drive(5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd14, 5'd15, 32'h404);
        #2 check("r14_link", Rn_val, 32'h100);
        @(posedge clk); #1;

        // Write to R15: one-cycle branch request; reads of 15 give pc_fetch.
        drive(5'd15, 32'h2000, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd15, 5'd15, 32'h408);
        #2 check("r15_read", Rn_val, 32'h408);
        @(posedge clk); #1;
        m_pc_load = 1'b1; m_pc_target = 32'h2000;
        check("pc_load_set", {31'd0, pc_load}, 32'd1);
        check("pc_target_set", pc_target, 32'h2000);
        drive(5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd0, 5'd0, 32'h40C);
        cycle("pc_drop");
        check("pc_load_one_cycle", {31'd0, pc_load}, 32'd0);
        check("pc_target_hold", pc_target, 32'h2000);

        // Flags bypass and hold; out-of-range index ignored and reads 0.
        drive(5'd20, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 4'b1010, 5'd20, 5'd20, 32'h410);
        #2 check("flags_bypass", {28'd0, flags}, 32'hA);
        check("r20_read", Rn_val, 32'd0);
        @(posedge clk); #1;
        m_flags = 4'b1010;
        drive(5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd20, 5'd0, 32'h414);
        #2 check("flags_held", {28'd0, flags}, 32'hA);
        check("r20_ignored", Rn_val, 32'd0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a write.
        drive(5'd7, 32'hCAFE_0007, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd7, 5'd7, 32'h418);
        cycle("load_r7");
        drive(5'd15, 32'h3000, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd7, 5'd7, 32'h41C);
        cycle("load_pc");
        drive(5'd7, 32'h1111_2222, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 4'h5, 5'd7, 5'd7, 32'h420);
        #2 reset_n = 1'b0;
        #1 drive(5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 5'd7, 5'd7, 32'h420);
        #1 check("arst_r7", Rn_val, 32'd0);
        check("arst_flags", {28'd0, flags}, 32'd0);
        check("arst_pc_load", {31'd0, pc_load}, 32'd0);
        check("arst_pc_target", pc_target, 32'd0);
        model_reset();
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // First edge after reset release must write.
        drive(5'd9, 32'h0909_0909, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd9, 5'd1, 32'h500);
        cycle("post_rst_wr");
        drive(5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 5'd9, 5'd9, 32'h504);
        cycle("post_rst_rd");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd, rn_i, rm_i;
            rd   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
            rn_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
            rm_i = ($urandom_range(0, 4) == 0) ? rn_i : 5'($urandom_range(0, 31));
            drive(rd, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0), $urandom, 1'($urandom_range(0, 1)),
                  4'($urandom), rn_i, rm_i, $urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
